// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master SRAM arbiter: FSM states, grant owner and
// the read data returned on a force-completed access.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the port not served last; otherwise data wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_valid,
  input  logic   d_valid,
  input  grant_e last_grant,
  output grant_e next_grant,
  output logic   any_req
);

  assign any_req = i_valid | d_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    next_grant = GNT_I;
    if (i_valid && d_valid)
      next_grant = (last_grant == GNT_D) ? GNT_I : GNT_D;
    else if (d_valid)
      next_grant = GNT_D;
  end
`else
  logic unused_last;
  assign unused_last = last_grant;

  always_comb begin
    next_grant = GNT_I;
    if (d_valid)
      next_grant = GNT_D;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-port SRAM with a response-timeout guard.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
//
// state    | meaning
// ST_IDLE  | no access in flight, SRAM outputs parked at 0
// ST_ISSUE | one-cycle mem_valid pulse for the granted port
// ST_RESP  | waiting for mem_ready or the timeout terminal count
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

  state_e        state;
  grant_e        grant;
  grant_e        last_served;
  grant_e        pick_grant;
  logic [CW-1:0] resp_left;
  logic          in_resp;
  logic          busy;
  logic          tmo_hit;
  logic          done;
  logic          i_req;
  logic          d_req;
  logic          any_req;
  logic [31:0]   resp_data;

  assign in_resp = (state == ST_RESP);
  assign busy    = (state != ST_IDLE);
  // A ready on the same terminal-count cycle beats the timeout.
  assign tmo_hit = in_resp && !mem_ready && (resp_left == '0);
  assign done    = in_resp && (mem_ready || tmo_hit);

  // The port completing this cycle still holds valid; it must not re-win.
  assign i_req = i_valid && !(in_resp && grant == GNT_I);
  assign d_req = d_valid && !(in_resp && grant == GNT_D);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      last_served <= GNT_D;
    else if (done)
      last_served <= grant;
  end
`else
  assign last_served = GNT_D;
`endif

  mem_arb_pick u_pick (
    .i_valid    (i_req),
    .d_valid    (d_req),
    .last_grant (last_served),
    .next_grant (pick_grant),
    .any_req    (any_req)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      grant     <= GNT_D;
      resp_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant <= pick_grant;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          resp_left <= TMO_LOAD;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (done) begin
            if (any_req) begin
              grant <= pick_grant;
              state <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            resp_left <= resp_left - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_valid = (state == ST_ISSUE);
  assign mem_addr  = !busy ? 32'h0 : ((grant == GNT_D) ? d_addr : i_addr);
  assign mem_wdata = (busy && grant == GNT_D) ? d_wdata : 32'h0;
  assign mem_wstrb = (busy && grant == GNT_D) ? d_wstrb : 4'h0;

  assign resp_data   = mem_ready ? mem_rdata : TIMEOUT_RDATA;
  assign i_ready     = done && (grant == GNT_I);
  assign d_ready     = done && (grant == GNT_D);
  assign i_rdata     = i_ready ? resp_data : 32'h0;
  assign d_rdata     = d_ready ? resp_data : 32'h0;
  assign timeout_err = tmo_hit;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, muxing, collisions, timeout, reset.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        resetn;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        timeout_err;

  int total;
  int bad;

  mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_valid     (i_valid),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_ready     (i_ready),
    .d_valid     (d_valid),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_wstrb     (d_wstrb),
    .d_rdata     (d_rdata),
    .d_ready     (d_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    i_valid   = 1'b0;
    i_addr    = 32'h0;
    d_valid   = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    d_wstrb   = 4'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mem_valid"}, {31'h0, mem_valid}, 32'h0);
    chk({tag, ".mem_addr"}, mem_addr, 32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, ".mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    chk({tag, ".i_ready"}, {31'h0, i_ready}, 32'h0);
    chk({tag, ".d_ready"}, {31'h0, d_ready}, 32'h0);
    chk({tag, ".i_rdata"}, i_rdata, 32'h0);
    chk({tag, ".d_rdata"}, d_rdata, 32'h0);
    chk({tag, ".tmo"}, {31'h0, timeout_err}, 32'h0);
  endtask

  initial begin
    grant_e exp_g;
    total  = 0;
    bad    = 0;
    resetn = 1'b1;
    clear_inputs();
    #2 resetn = 1'b0;
    #1 chk_quiet("reset");
    do_reset();

    // single fetch
    i_valid = 1'b1; i_addr = 32'h10;
    #1 chk("f.c0.mem_valid", {31'h0, mem_valid}, 32'h0);
    step();
    chk("f.c1.mem_valid", {31'h0, mem_valid}, 32'h1);
    chk("f.c1.mem_addr", mem_addr, 32'h10);
    chk("f.c1.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("f.c1.i_ready", {31'h0, i_ready}, 32'h0);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h13;
    #1 chk("f.c2.i_ready", {31'h0, i_ready}, 32'h1);
    chk("f.c2.i_rdata", i_rdata, 32'h13);
    chk("f.c2.d_ready", {31'h0, d_ready}, 32'h0);
    chk("f.c2.tmo", {31'h0, timeout_err}, 32'h0);
    step();
    clear_inputs();
    #1 chk_quiet("f.c3");

    // byte write
    d_valid = 1'b1; d_addr = 32'h104; d_wdata = 32'hAABBCCDD; d_wstrb = 4'b0001;
    step();
    chk("w.c1.mem_valid", {31'h0, mem_valid}, 32'h1);
    chk("w.c1.mem_addr", mem_addr, 32'h104);
    chk("w.c1.mem_wdata", mem_wdata, 32'hAABBCCDD);
    chk("w.c1.mem_wstrb", {28'h0, mem_wstrb}, 32'h1);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h55;
    #1 chk("w.c2.d_ready", {31'h0, d_ready}, 32'h1);
    chk("w.c2.d_rdata", d_rdata, 32'h55);
    chk("w.c2.i_ready", {31'h0, i_ready}, 32'h0);
    step();
    clear_inputs();
    #1 chk_quiet("w.c3");

    // collision with both valids held for four accesses
    do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = GNT_I;
`else
    exp_g = GNT_D;
`endif
    i_valid = 1'b1; i_addr = 32'h200;
    d_valid = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    #1 chk("col.c0.mem_valid", {31'h0, mem_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      mem_ready = 1'b0;
      #1 chk($sformatf("col%0d.mem_valid", k), {31'h0, mem_valid}, 32'h1);
      chk($sformatf("col%0d.mem_addr", k), mem_addr, (exp_g == GNT_D) ? 32'h300 : 32'h200);
      chk($sformatf("col%0d.mem_wstrb", k), {28'h0, mem_wstrb}, (exp_g == GNT_D) ? 32'hF : 32'h0);
      chk($sformatf("col%0d.early_rdy", k), {30'h0, i_ready, d_ready}, 32'h0);
      step();
      mem_ready = 1'b1; mem_rdata = 32'h1000 + k;
      #1 chk($sformatf("col%0d.i_ready", k), {31'h0, i_ready}, (exp_g == GNT_I) ? 32'h1 : 32'h0);
      chk($sformatf("col%0d.d_ready", k), {31'h0, d_ready}, (exp_g == GNT_D) ? 32'h1 : 32'h0);
      chk($sformatf("col%0d.rdata", k), (exp_g == GNT_I) ? i_rdata : d_rdata, 32'h1000 + k);
      chk($sformatf("col%0d.other_rdata", k), (exp_g == GNT_I) ? d_rdata : i_rdata, 32'h0);
      exp_g = (exp_g == GNT_I) ? GNT_D : GNT_I;
    end

    // timeout on a hung fetch
    do_reset();
    i_valid = 1'b1; i_addr = 32'h40;
    step();
    chk("t.c1.mem_valid", {31'h0, mem_valid}, 32'h1);
    for (int r = 1; r <= 15; r++) begin
      step();
      mem_rdata = 32'hDEAD0000 + r;
      #1 chk($sformatf("t.resp%0d", r), {30'h0, i_ready, timeout_err}, 32'h0);
    end
    step();
    mem_rdata = 32'hDEADBEEF;
    #1 chk("t.resp16.i_ready", {31'h0, i_ready}, 32'h1);
    chk("t.resp16.i_rdata", i_rdata, 32'h0);
    chk("t.resp16.tmo", {31'h0, timeout_err}, 32'h1);
    step();
    clear_inputs();
    #1 chk_quiet("t.after");

    // ready on exactly the terminal cycle beats the timeout
    i_valid = 1'b1; i_addr = 32'h44;
    step();
    for (int r = 1; r <= 15; r++) begin
      step();
      #1 chk($sformatf("tr.resp%0d", r), {30'h0, i_ready, timeout_err}, 32'h0);
    end
    step();
    mem_ready = 1'b1; mem_rdata = 32'h77;
    #1 chk("tr.resp16.i_ready", {31'h0, i_ready}, 32'h1);
    chk("tr.resp16.i_rdata", i_rdata, 32'h77);
    chk("tr.resp16.tmo", {31'h0, timeout_err}, 32'h0);
    step();
    clear_inputs();
    #1 chk_quiet("tr.after");

    // reset in the middle of a response wait
    d_valid = 1'b1; d_addr = 32'h500; d_wdata = 32'hCAFEF00D; d_wstrb = 4'hF;
    step();
    step();
    #1 chk("rst.resp.mem_addr", mem_addr, 32'h500);
    resetn = 1'b0;
    #1 chk_quiet("rst.async");
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h99;
    #1 chk_quiet("rst.stale");
    step();
    clear_inputs();
    #1 chk_quiet("rst.idle");
    i_valid = 1'b1; i_addr = 32'h60;
    step();
    chk("rst.next.mem_valid", {31'h0, mem_valid}, 32'h1);
    chk("rst.next.mem_addr", mem_addr, 32'h60);
    step();
    mem_ready = 1'b1; mem_rdata = 32'hABCD;
    #1 chk("rst.next.i_ready", {31'h0, i_ready}, 32'h1);
    chk("rst.next.i_rdata", i_rdata, 32'hABCD);
    step();
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
